// File: rtl/scanline_relpos_gen.sv
// Vertical phase tracker for scanline_emu: tags each output line with its
// fractional position and index inside the source line, aligned to 2-cycle delayed video.
module scanline_relpos_gen #(
  parameter int FRAC_W = 8,
  parameter int INT_W  = 11,
  parameter int DATA_W = 24
) (
  input  logic                    VCLK_i,
  input  logic                    VRST_i,
  input  logic                    HSYNC_i,
  input  logic                    VSYNC_i,
  input  logic                    DE_i,
  input  logic [DATA_W-1:0]       vdata_i,
  input  logic [INT_W+FRAC_W-1:0] vstep_i,
  input  logic [FRAC_W-1:0]       vinit_i,
  output logic                    HSYNC_o,
  output logic                    VSYNC_o,
  output logic                    DE_o,
  output logic [DATA_W-1:0]       vdata_o,
  output logic [FRAC_W-1:0]       sl_rel_pos_o,
  output logic                    new_src_line_o,
  output logic [INT_W-1:0]        src_line_o
);

  localparam int ACC_W = INT_W + FRAC_W;

  logic              hs_q, vs_q, de_q;
  logic [DATA_W-1:0] vdata_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  vstep_sh;
  logic              first_line;
  logic              int_chg;

  logic              hs_fall, vs_fall, de_fall;
  logic [FRAC_W:0]   frac_sum;
  logic [INT_W:0]    int_sum;
  logic [INT_W-1:0]  int_next;

  // The second delay stage doubles as the "previous" sample for edge detection,
  // so tag updates land on the same edge where HSYNC_o falls.
  assign hs_fall = HSYNC_o & ~hs_q;
  assign vs_fall = VSYNC_o & ~vs_q;
  assign de_fall = DE_o & ~de_q;

  always_comb begin
    frac_sum = {1'b0, acc[FRAC_W-1:0]} + {1'b0, vstep_sh[FRAC_W-1:0]};
    int_sum  = {1'b0, acc[ACC_W-1:FRAC_W]} + {1'b0, vstep_sh[ACC_W-1:FRAC_W]}
             + {{INT_W{1'b0}}, frac_sum[FRAC_W]};
    int_next = int_sum[INT_W] ? '1 : int_sum[INT_W-1:0];
  end

  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      de_q           <= 1'b0;
      vdata_q        <= '0;
      HSYNC_o        <= 1'b1;
      VSYNC_o        <= 1'b1;
      DE_o           <= 1'b0;
      vdata_o        <= '0;
      acc            <= '0;
      vstep_sh       <= '0;
      first_line     <= 1'b0;
      int_chg        <= 1'b0;
      sl_rel_pos_o   <= '0;
      new_src_line_o <= 1'b0;
      src_line_o     <= '0;
    end else begin
      hs_q    <= HSYNC_i;
      vs_q    <= VSYNC_i;
      de_q    <= DE_i;
      vdata_q <= vdata_i;
      HSYNC_o <= hs_q;
      VSYNC_o <= vs_q;
      DE_o    <= de_q;
      vdata_o <= vdata_q;

      // vinit goes straight into acc on the capture edge, so only vstep needs a shadow
      if (vs_fall) begin
        vstep_sh <= vstep_i;
        acc      <= {{INT_W{1'b0}}, vinit_i};
      end else if (de_fall) begin
        acc <= {int_next, frac_sum[FRAC_W-1:0]};
      end

      if (hs_fall) begin
        sl_rel_pos_o   <= acc[FRAC_W-1:0];
        src_line_o     <= acc[ACC_W-1:FRAC_W];
        new_src_line_o <= first_line | int_chg;
        first_line     <= 1'b0;
        int_chg        <= 1'b0;
      end

      // Setting events win over the latch-time clear when they coincide.
      if (vs_fall) begin
        first_line <= 1'b1;
        int_chg    <= 1'b0;
      end else if (de_fall && (int_next != acc[ACC_W-1:FRAC_W])) begin
        int_chg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scanline_relpos_gen.sv
// Self-checking bench for scanline_relpos_gen: table vectors, directed corner
// sequences and random frames against an arithmetic phase model.
module tb_scanline_relpos_gen;

  logic        clk = 1'b0;
  logic        VRST_i = 1'b1;
  logic        HSYNC_i = 1'b1;
  logic        VSYNC_i = 1'b1;
  logic        DE_i = 1'b0;
  logic [23:0] vdata_i = '0;
  logic [18:0] vstep_i = '0;
  logic [7:0]  vinit_i = '0;
  logic        HSYNC_o, VSYNC_o, DE_o;
  logic [23:0] vdata_o;
  logic [7:0]  sl_rel_pos_o;
  logic        new_src_line_o;
  logic [10:0] src_line_o;

  scanline_relpos_gen #(.FRAC_W(8), .INT_W(11), .DATA_W(24)) dut (
    .VCLK_i(clk), .VRST_i(VRST_i), .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .vdata_i(vdata_i), .vstep_i(vstep_i), .vinit_i(vinit_i),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o), .vdata_o(vdata_o),
    .sl_rel_pos_o(sl_rel_pos_o), .new_src_line_o(new_src_line_o), .src_line_o(src_line_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- pipeline and tag-stability monitor ----------------
  localparam logic [26:0] RST_V = {1'b1, 1'b1, 1'b0, 24'h0};
  logic [26:0] p1, p2;
  logic        rst_edge;
  logic        mon_en = 1'b0;
  logic        hs_prev = 1'b1;
  logic [19:0] tags_prev = '0;

  always @(posedge clk) begin
    p1       <= VRST_i ? RST_V : {HSYNC_i, VSYNC_i, DE_i, vdata_i};
    p2       <= VRST_i ? RST_V : p1;
    rst_edge <= VRST_i;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pipe", {37'd0, HSYNC_o, VSYNC_o, DE_o, vdata_o}, {37'd0, p2});
      if (!rst_edge && !(hs_prev && !HSYNC_o))
        chk("tag_hold", {44'd0, sl_rel_pos_o, new_src_line_o, src_line_o}, {44'd0, tags_prev});
      hs_prev   = HSYNC_o;
      tags_prev = {sl_rel_pos_o, new_src_line_o, src_line_o};
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  got_rel [8];
  logic        got_new [8];
  logic [10:0] got_src [8];
  logic [7:0]  exp_rel [8];
  logic        exp_new [8];
  logic [10:0] exp_src [8];

  task automatic run_line(input int k);
    HSYNC_i = 1'b0;
    tick(); tick();
    got_rel[k] = sl_rel_pos_o;
    got_new[k] = new_src_line_o;
    got_src[k] = src_line_o;
    tick(); tick();
    HSYNC_i = 1'b1;
    tick(); tick();
    DE_i = 1'b1;
    repeat (8) begin
      vdata_i = 24'($urandom);
      tick();
    end
    DE_i = 1'b0;
    tick(); tick();
  endtask

  task automatic run_frame(input logic [7:0] vi, input logic [18:0] vs, input int n,
                           input logic [18:0] vs_mid, input bit collide);
    vinit_i = vi;
    vstep_i = vs;
    if (collide) begin
      DE_i = 1'b1;
      tick(); tick();
      DE_i = 1'b0;
    end
    VSYNC_i = 1'b0;
    tick(); tick();
    VSYNC_i = 1'b1;
    tick(); tick();
    for (int k = 0; k < n; k++) begin
      run_line(k);
      if (k == 0) vstep_i = vs_mid;
    end
  endtask

  // Line k sits at vinit + k*vstep; the fraction wraps freely while the index
  // clips at 2047, and a line is "new" when its index differs from the previous one.
  task automatic model_frame(input logic [7:0] vi, input logic [18:0] vs, input int n);
    longint total, idx, prev_idx;
    prev_idx = -1;
    for (int k = 0; k < n; k++) begin
      total = longint'(vi) + longint'(k) * longint'(vs);
      idx = total / 256;
      if (idx > 2047) idx = 2047;
      exp_rel[k] = 8'(total % 256);
      exp_src[k] = 11'(idx);
      exp_new[k] = (k == 0) || (idx != prev_idx);
      prev_idx = idx;
    end
  endtask

  task automatic cmp_frame(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s rel[%0d]", tag, k), {56'd0, got_rel[k]}, {56'd0, exp_rel[k]});
      chk($sformatf("%s new[%0d]", tag, k), {63'd0, got_new[k]}, {63'd0, exp_new[k]});
      chk($sformatf("%s src[%0d]", tag, k), {53'd0, got_src[k]}, {53'd0, exp_src[k]});
    end
  endtask

  // ---------------- vector table (line 0 is the rightmost field) ----------------
  typedef struct packed {
    logic [7:0]       vi;
    logic [18:0]      vs;
    logic [3:0]       n;
    logic [5:0][7:0]  rel;
    logic [5:0]       nw;
    logic [5:0][10:0] src;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{vi: 8'h00, vs: 19'h080, n: 4'd4,
                rel: {8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00}, nw: 6'b000101,
                src: {11'd0, 11'd0, 11'd1, 11'd1, 11'd0, 11'd0}};
    vecs[1] = '{vi: 8'h00, vs: 19'h055, n: 4'd5,
                rel: {8'h00, 8'h54, 8'hFF, 8'hAA, 8'h55, 8'h00}, nw: 6'b010001,
                src: {11'd0, 11'd1, 11'd0, 11'd0, 11'd0, 11'd0}};
    vecs[2] = '{vi: 8'hF0, vs: 19'h020, n: 4'd3,
                rel: {8'h00, 8'h00, 8'h00, 8'h30, 8'h10, 8'hF0}, nw: 6'b000011,
                src: {11'd0, 11'd0, 11'd0, 11'd1, 11'd1, 11'd0}};
    vecs[3] = '{vi: 8'h00, vs: 19'h7FF00, n: 4'd4,
                rel: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nw: 6'b000011,
                src: {11'd0, 11'd0, 11'h7FF, 11'h7FF, 11'h7FF, 11'd0}};
    vecs[4] = '{vi: 8'h33, vs: 19'h000, n: 4'd3,
                rel: {8'h00, 8'h00, 8'h00, 8'h33, 8'h33, 8'h33}, nw: 6'b000001,
                src: {11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0}};

    // reset state
    tick(); tick(); tick();
    chk("rst HSYNC_o", {63'd0, HSYNC_o}, 64'd1);
    chk("rst VSYNC_o", {63'd0, VSYNC_o}, 64'd1);
    chk("rst DE_o", {63'd0, DE_o}, 64'd0);
    chk("rst vdata_o", {40'd0, vdata_o}, 64'd0);
    chk("rst rel", {56'd0, sl_rel_pos_o}, 64'd0);
    chk("rst new", {63'd0, new_src_line_o}, 64'd0);
    chk("rst src", {53'd0, src_line_o}, 64'd0);
    VRST_i = 1'b0;
    mon_en = 1'b1;
    tick();

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].vi, vecs[v].vs, int'(vecs[v].n), vecs[v].vs, 1'b0);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        exp_rel[k] = vecs[v].rel[k];
        exp_new[k] = vecs[v].nw[k];
        exp_src[k] = vecs[v].src[k];
      end
      cmp_frame($sformatf("vec%0d", v), int'(vecs[v].n));
    end

    // vstep changed mid-frame only applies from the next frame
    run_frame(8'h00, 19'h080, 4, 19'h040, 1'b0);
    model_frame(8'h00, 19'h080, 4);
    cmp_frame("midchg", 4);
    run_frame(8'h00, 19'h040, 5, 19'h040, 1'b0);
    model_frame(8'h00, 19'h040, 5);
    cmp_frame("nextfrm", 5);

    // VSYNC and DE falling together: vinit is loaded and the add is dropped
    run_frame(8'h10, 19'h040, 3, 19'h040, 1'b1);
    model_frame(8'h10, 19'h040, 3);
    cmp_frame("collide", 3);

    // reset mid-line
    HSYNC_i = 1'b0;
    tick(); tick(); tick();
    HSYNC_i = 1'b1;
    DE_i = 1'b1;
    tick(); tick();
    VRST_i = 1'b1;
    tick();
    VRST_i = 1'b0;
    chk("mrst HSYNC_o", {63'd0, HSYNC_o}, 64'd1);
    chk("mrst VSYNC_o", {63'd0, VSYNC_o}, 64'd1);
    chk("mrst DE_o", {63'd0, DE_o}, 64'd0);
    chk("mrst vdata_o", {40'd0, vdata_o}, 64'd0);
    chk("mrst rel", {56'd0, sl_rel_pos_o}, 64'd0);
    chk("mrst new", {63'd0, new_src_line_o}, 64'd0);
    chk("mrst src", {53'd0, src_line_o}, 64'd0);
    tick(); tick(); tick();
    DE_i = 1'b0;
    tick(); tick();
    vstep_i = 19'h0C0;
    for (int k = 0; k < 2; k++) begin
      run_line(k);
      exp_rel[k] = '0;
      exp_new[k] = 1'b0;
      exp_src[k] = '0;
    end
    cmp_frame("postrst", 2);
    run_frame(8'h08, 19'h100, 3, 19'h100, 1'b0);
    model_frame(8'h08, 19'h100, 3);
    cmp_frame("resume", 3);

    // random frames against the phase model
    for (int f = 0; f < 12; f++) begin
      logic [7:0]  vi;
      logic [18:0] vs, vm;
      int          n;
      bit          col;
      vi  = 8'($urandom);
      vs  = ($urandom_range(0, 3) == 0) ? 19'($urandom) : 19'($urandom_range(0, 19'h3FF));
      vm  = 19'($urandom);
      n   = int'($urandom_range(2, 8));
      col = ($urandom_range(0, 3) == 0);
      run_frame(vi, vs, n, vm, col);
      model_frame(vi, vs, n);
      cmp_frame($sformatf("rnd%0d", f), n);
    end

    tick(); tick();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
